bus_arbiter: RTL
================

# bus_arbiter

Two-port arbiter and access sequencer for the shared address/data bus that feeds the I/O manager (SRAM plus memory-mapped LEDs, buttons and switches at 0xFFFC–0xFFFF). It sits between the CPU (port 0) and a second bus master, such as a display scanner or DMA (port 1). It grants the bus round-robin and holds address, direction and write data stable for a fixed number of wait cycles. It then returns read data with a one-cycle acknowledge to the winning requester.

## Interface
Parameters:
- WAIT, 2: cycles the bus is held per access; legal range 1..15. The counter is 4 bits wide.

Ports:
- clk  in  1  system clock; everything is sampled on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req0  in  1  port 0 request; held high until ack0.
- we0  in  1  port 0 direction; 1 = write, 0 = read.
- addr0  in  16  port 0 address.
- wdata0  in  16  port 0 write data.
- ack0  out  1  one-cycle pulse when the port 0 access completes.
- req1, we1, addr1, wdata1, ack1: the same signals for port 1.
- rdata  out  16  registered read data; valid in the ack cycle and held until the next capture.
- bus_addr  out  16  address to the I/O manager (dir_in).
- bus_oe  out  1  bus direction to the I/O manager; 1 = write cycle, 0 = read.
- bus_wdata  out  16  write data to the I/O manager transceiver.
- bus_rdata  in  16  read data from the I/O manager.
- busy  out  1  high in ACCESS and DONE.
- owner  out  1  index of the port currently or most recently granted.

## Operation
- State machine states:
  - IDLE: samples req0/req1. If neither is high, stay in IDLE. If one is high, grant it. If both are high, grant the port not equal to `last`. Go to ACCESS, load cnt = WAIT-1, and latch the winner's addr, we and wdata into the bus registers.
  - ACCESS: bus outputs are frozen. While cnt ≠ 0, decrement cnt. When cnt = 0, capture bus_rdata into rdata (reads only; writes leave rdata unchanged), set `last` = owner, and go to DONE.
  - DONE: ackN = 1 for the owner only. bus_oe returns to 0. Next state is IDLE.
- Round-robin state `last` resets to 1, so port 0 wins the first contention. A port that keeps req high back-to-back alternates with the other requester whenever both are pending.
- Requester inputs are sampled only at the IDLE→ACCESS edge. Changes to addr, wdata or we during ACCESS are ignored.
- If req drops mid-access, the access still completes and ack still pulses. The requester ignores the ack.
- A request that is still high in the DONE cycle is treated as a new request in the following IDLE cycle.
- bus_oe is 1 only during ACCESS of a write. This prevents any write strobe toward the SRAM or LED registers outside a granted write.
- In IDLE and DONE: bus_addr and bus_wdata keep their last values, and bus_oe = 0.

## Timing
- Reset (asynchronous, immediate on falling reset):
  - state = IDLE, cnt = 0, last = 1, owner = 0.
  - ack0 = ack1 = 0, busy = 0, rdata = 0x0000, bus_addr = 0x0000, bus_oe = 0, bus_wdata = 0x0000.
- Reset asserted mid-access aborts the access. No ack is issued, and the interrupted request must be re-presented after release.
- Latency: req sampled high at edge N (in IDLE). ACCESS covers cycles N+1 .. N+WAIT. rdata is updated and ack is high in cycle N+WAIT+1. The next grant edge is N+WAIT+2.
- Throughput: one transaction per WAIT+2 cycles.
- ack0 and ack1 are never high in the same cycle. Each is a single-cycle pulse.
- All outputs are registered. There are no combinational paths from any input to any output.

## Test plan
- Reset values: assert reset mid-ACCESS of a port 0 write to 0xFFFF. All outputs drop to their reset values immediately, bus_oe = 0, and no ack0 is issued.
- Single read: WAIT=2, port 0 reads 0x0010 with bus_rdata = 0xBEEF.
  - bus_addr = 0x0010 for 2 cycles with bus_oe = 0.
  - ack0 rises 3 cycles after the request edge, with rdata = 0xBEEF.
- Single write: port 1 writes 0x03FF to 0xFFFE.
  - bus_oe = 1 for exactly WAIT cycles with bus_wdata = 0x03FF.
  - ack1 pulses, and rdata is unchanged.
- Contention: both ports request continuously from reset. Grants run 0, 1, 0, 1. owner and ack alternate, and each ack is one cycle wide.
- Withdrawn request: port 1 drops req1 in the first ACCESS cycle. The access still completes with an ack1 pulse, then the arbiter returns to IDLE and busy = 0.
- Input freeze: port 0 changes addr0 from 0x0004 to 0x0008 during ACCESS. bus_addr stays 0x0004 until DONE.

Source files
------------

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-port round-robin arbiter and fixed-wait access sequencer
// Every output is a register fed from next-state logic; no input reaches an output combinationally.
module bus_arbiter #(
  parameter int WAIT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        we0,
  input  logic [15:0] addr0,
  input  logic [15:0] wdata0,
  output logic        ack0,
  input  logic        req1,
  input  logic        we1,
  input  logic [15:0] addr1,
  input  logic [15:0] wdata1,
  output logic        ack1,
  output logic [15:0] rdata,
  output logic [15:0] bus_addr,
  output logic        bus_oe,
  output logic [15:0] bus_wdata,
  input  logic [15:0] bus_rdata,
  output logic        busy,
  output logic        owner
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT - 1);

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic        last, last_nx;
  logic        owner_nx;
  logic        bus_we, bus_we_nx;
  logic        grant;
  logic [15:0] bus_addr_nx, bus_wdata_nx, rdata_nx;
  logic        ack0_nx, ack1_nx, busy_nx, bus_oe_nx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      last      <= 1'b1;
      owner     <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 16'h0000;
      bus_wdata <= 16'h0000;
      rdata     <= 16'h0000;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      busy      <= 1'b0;
      bus_oe    <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      last      <= last_nx;
      owner     <= owner_nx;
      bus_we    <= bus_we_nx;
      bus_addr  <= bus_addr_nx;
      bus_wdata <= bus_wdata_nx;
      rdata     <= rdata_nx;
      ack0      <= ack0_nx;
      ack1      <= ack1_nx;
      busy      <= busy_nx;
      bus_oe    <= bus_oe_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    last_nx      = last;
    owner_nx     = owner;
    bus_we_nx    = bus_we;
    bus_addr_nx  = bus_addr;
    bus_wdata_nx = bus_wdata;
    rdata_nx     = rdata;
    grant        = 1'b0;

    case (state)
      IDLE: begin
        if (req0 || req1) begin
          // Under contention the port that did not win last time goes first.
          grant        = (req0 && req1) ? ~last : req1;
          state_nx     = ACCESS;
          cnt_nx       = CNT_INIT;
          owner_nx     = grant;
          bus_we_nx    = grant ? we1 : we0;
          bus_addr_nx  = grant ? addr1 : addr0;
          bus_wdata_nx = grant ? wdata1 : wdata0;
        end
      end
      ACCESS: begin
        if (cnt != 4'd0) begin
          cnt_nx = cnt - 4'd1;
        end else begin
          if (!bus_we) rdata_nx = bus_rdata;
          last_nx  = owner;
          state_nx = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase

    // Registered outputs are decoded from the state being entered.
    ack0_nx   = (state_nx == DONE) && !owner_nx;
    ack1_nx   = (state_nx == DONE) && owner_nx;
    busy_nx   = (state_nx != IDLE);
    bus_oe_nx = (state_nx == ACCESS) && bus_we_nx;
  end

endmodule
